// File: rtl/pnc_target_responder.sv
`default_nettype none
// =============================================================================
// Module   : pnc_target_responder
// Purpose  : Target-side register-bank responder on the neuron-controller
//            downstream bus. Define PNC_READ_CLEAR_EN for read-and-clear reads.
// Revision : 1.0 - initial release
// =============================================================================
module pnc_target_responder #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              RC,
    input  logic              W_EN,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data,
    output logic              req_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  access_cnt
);

    localparam int               c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_addr_ok;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_idle;
    logic                w_addr_ok;
    logic                w_cmd_wr;
    logic                w_cmd_rd;
    logic                w_cmd_ill;
    logic                w_err_set;
    logic                w_cnt_inc;
    logic                w_mem_we;
    logic [c_IDX_W-1:0]  w_mem_widx;
    logic [DATA_W-1:0]   w_mem_wdata;

    assign w_idle    = (r_state == S_IDLE);
    assign w_addr_ok = ({1'b0, Addr} < c_DEPTH);
    assign w_cmd_wr  = EN &  W_EN & ~RC;
    assign w_cmd_rd  = EN & ~W_EN &  RC;
    assign w_cmd_ill = EN &  W_EN &  RC;

    // Out-of-range reads still walk FETCH/RESP so the requester always gets a response.
    assign w_err_set = w_idle & (w_cmd_ill | ((w_cmd_wr | w_cmd_rd) & ~w_addr_ok));
    assign w_cnt_inc = w_idle & (w_cmd_wr | w_cmd_rd) & w_addr_ok;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_widx  = Addr[c_IDX_W-1:0];
        w_mem_wdata = Data;
        if (rst && w_idle && w_cmd_wr && w_addr_ok) begin
            w_mem_we = 1'b1;
        end
`ifdef PNC_READ_CLEAR_EN
        if (rst && (r_state == S_FETCH) && r_addr_ok) begin
            w_mem_we    = 1'b1;
            w_mem_widx  = r_idx;
            w_mem_wdata = '0;
        end
`endif
    end

    // Bank contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_addr_ok  <= 1'b0;
            req_ready  <= 1'b1;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            err        <= 1'b0;
            access_cnt <= '0;
        end else begin
            // A new error outranks a simultaneous clear.
            if (w_err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            if (w_cnt_inc && (access_cnt != c_CNT_MAX)) begin
                access_cnt <= access_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_rd) begin
                        r_idx     <= Addr[c_IDX_W-1:0];
                        r_addr_ok <= w_addr_ok;
                        req_ready <= 1'b0;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_data  <= r_addr_ok ? r_mem[r_idx] : '0;
                    rd_valid <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rd_valid  <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pnc_target_responder.sv
`default_nettype none
// =============================================================================
// Module   : tb_pnc_target_responder
// Purpose  : Self-checking bench for pnc_target_responder (vector table plus
//            read-data scoreboard). Honours PNC_READ_CLEAR_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_pnc_target_responder;

`ifdef PNC_READ_CLEAR_EN
    localparam bit c_RC = 1'b1;
`else
    localparam bit c_RC = 1'b0;
`endif

    localparam logic [2:0] K_WR  = 3'd0;
    localparam logic [2:0] K_RD  = 3'd1;
    localparam logic [2:0] K_ILL = 3'd2;
    localparam logic [2:0] K_NOP = 3'd3;
    localparam logic [2:0] K_CLR = 3'd4;
    localparam int         NV    = 23;

    typedef struct {
        logic [2:0]  kind;
        logic [6:0]  addr;
        logic [31:0] data;
        logic        clr;
        logic [31:0] rdata;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN, RC, W_EN, rd_ready, err_clr;
    logic [6:0]  Addr;
    logic [31:0] Data;
    logic        req_ready, rd_valid, err;
    logic [31:0] rd_data;
    logic [15:0] access_cnt;

    logic        s_EN, s_RC, s_W_EN, s_rd_ready, s_err_clr;
    logic [6:0]  s_Addr;
    logic [31:0] s_Data;
    logic        s_req_ready, s_rd_valid, s_err;
    logic [31:0] s_rd_data;
    logic [7:0]  s_access_cnt;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[NV];

    always #5 clk = ~clk;

    pnc_target_responder #(.DEPTH(64), .DATA_W(32), .ADDR_W(7), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .EN(EN), .RC(RC), .W_EN(W_EN), .Addr(Addr), .Data(Data),
        .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .err(err), .err_clr(err_clr), .access_cnt(access_cnt)
    );

    pnc_target_responder #(.DEPTH(128), .DATA_W(32), .ADDR_W(7), .CNT_W(8)) u_sat (
        .clk(clk), .rst(rst), .EN(s_EN), .RC(s_RC), .W_EN(s_W_EN), .Addr(s_Addr), .Data(s_Data),
        .req_ready(s_req_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_ready(s_rd_ready),
        .err(s_err), .err_clr(s_err_clr), .access_cnt(s_access_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_cmd(input logic en, input logic rc, input logic wen,
                          input logic [6:0] a, input logic [31:0] d, input logic clr);
        EN = en; RC = rc; W_EN = wen; Addr = a; Data = d; err_clr = clr;
        tick();
        EN = 1'b0; RC = 1'b0; W_EN = 1'b0; err_clr = 1'b0;
    endtask

    task automatic start_read(input logic [6:0] a, input logic [31:0] exp, input logic ready_now);
        exp_q.push_back(exp);
        EN = 1'b1; RC = 1'b1; W_EN = 1'b0; Addr = a; rd_ready = ready_now;
        tick();
        EN = 1'b0; RC = 1'b0;
        chk("fetch_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("fetch_req_ready", {31'b0, req_ready}, 32'd0);
        tick();
        chk("resp_rd_valid", {31'b0, rd_valid}, 32'd1);
    endtask

    task automatic finish_read();
        logic done;
        done = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            tick();
            if (!rd_valid) done = 1'b1;
        end
        chk("resp_handshake_timeout", {31'b0, done}, 32'd1);
        rd_ready = 1'b0;
        chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    // Scoreboard: a response is consumed on the edge following a valid&ready sample.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{K_WR,  7'd5,   32'hDEADBEEF, 1'b0, 32'h0,                           1'b0, 16'd1};
        vecs[1]  = '{K_RD,  7'd5,   32'h0,        1'b0, 32'hDEADBEEF,                    1'b0, 16'd2};
        vecs[2]  = '{K_ILL, 7'd5,   32'h0,        1'b0, 32'h0,                           1'b1, 16'd2};
        vecs[3]  = '{K_RD,  7'd5,   32'h0,        1'b0, c_RC ? 32'h0 : 32'hDEADBEEF,     1'b1, 16'd3};
        vecs[4]  = '{K_CLR, 7'd0,   32'h0,        1'b1, 32'h0,                           1'b0, 16'd3};
        vecs[5]  = '{K_ILL, 7'd9,   32'h9,        1'b1, 32'h0,                           1'b1, 16'd3};
        vecs[6]  = '{K_CLR, 7'd0,   32'h0,        1'b1, 32'h0,                           1'b0, 16'd3};
        vecs[7]  = '{K_RD,  7'd100, 32'h0,        1'b0, 32'h0,                           1'b1, 16'd3};
        vecs[8]  = '{K_CLR, 7'd0,   32'h0,        1'b1, 32'h0,                           1'b0, 16'd3};
        vecs[9]  = '{K_WR,  7'd100, 32'h55555555, 1'b0, 32'h0,                           1'b1, 16'd3};
        vecs[10] = '{K_NOP, 7'd3,   32'h3,        1'b0, 32'h0,                           1'b1, 16'd3};
        vecs[11] = '{K_CLR, 7'd0,   32'h0,        1'b1, 32'h0,                           1'b0, 16'd3};
        vecs[12] = '{K_WR,  7'd7,   32'h00001234, 1'b0, 32'h0,                           1'b0, 16'd4};
        vecs[13] = '{K_RD,  7'd7,   32'h0,        1'b0, 32'h00001234,                    1'b0, 16'd5};
        vecs[14] = '{K_RD,  7'd7,   32'h0,        1'b0, c_RC ? 32'h0 : 32'h00001234,     1'b0, 16'd6};
        vecs[15] = '{K_WR,  7'd63,  32'hAAAA5555, 1'b0, 32'h0,                           1'b0, 16'd7};
        vecs[16] = '{K_RD,  7'd63,  32'h0,        1'b0, 32'hAAAA5555,                    1'b0, 16'd8};
        vecs[17] = '{K_RD,  7'd64,  32'h0,        1'b0, 32'h0,                           1'b1, 16'd8};
        vecs[18] = '{K_CLR, 7'd0,   32'h0,        1'b1, 32'h0,                           1'b0, 16'd8};
        vecs[19] = '{K_WR,  7'd0,   32'h11111111, 1'b0, 32'h0,                           1'b0, 16'd9};
        vecs[20] = '{K_WR,  7'd64,  32'h22222222, 1'b0, 32'h0,                           1'b1, 16'd9};
        vecs[21] = '{K_RD,  7'd0,   32'h0,        1'b0, 32'h11111111,                    1'b1, 16'd10};
        vecs[22] = '{K_CLR, 7'd0,   32'h0,        1'b1, 32'h0,                           1'b0, 16'd10};

        rst = 1'b0; EN = 1'b0; RC = 1'b0; W_EN = 1'b0; Addr = '0; Data = '0;
        rd_ready = 1'b0; err_clr = 1'b0;
        s_EN = 1'b0; s_RC = 1'b0; s_W_EN = 1'b0; s_Addr = '0; s_Data = '0;
        s_rd_ready = 1'b1; s_err_clr = 1'b0;
        tick();
        tick();
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_access_cnt", {16'b0, access_cnt}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            case (vecs[i].kind)
                K_WR:  op_cmd(1'b1, 1'b0, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].clr);
                K_ILL: op_cmd(1'b1, 1'b1, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].clr);
                K_NOP: op_cmd(1'b1, 1'b0, 1'b0, vecs[i].addr, vecs[i].data, vecs[i].clr);
                K_CLR: op_cmd(1'b0, 1'b0, 1'b0, vecs[i].addr, vecs[i].data, 1'b1);
                default: begin
                    start_read(vecs[i].addr, vecs[i].rdata, 1'b1);
                    finish_read();
                end
            endcase
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_access_cnt", i), {16'b0, access_cnt}, {16'b0, vecs[i].exp_cnt});
        end

        // Back-pressure: response held while a write attempt is ignored.
        op_cmd(1'b1, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b0);
        chk("bp_pre_cnt", {16'b0, access_cnt}, 32'd11);
        start_read(7'd5, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                EN = 1'b1; W_EN = 1'b1; RC = 1'b0; Addr = 7'd5; Data = 32'h0;
            end
            tick();
            EN = 1'b0; W_EN = 1'b0;
            chk("bp_rd_valid", {31'b0, rd_valid}, 32'd1);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_rd_data", rd_data, 32'hDEADBEEF);
        end
        finish_read();
        chk("bp_post_cnt", {16'b0, access_cnt}, 32'd12);
        chk("bp_post_err", {31'b0, err}, 32'd0);
        chk("bp_data_kept", rd_data, 32'hDEADBEEF);
        start_read(7'd5, c_RC ? 32'h0 : 32'hDEADBEEF, 1'b1);
        finish_read();
        chk("bp_reread_cnt", {16'b0, access_cnt}, 32'd13);

        // Reset in the middle of a held response.
        op_cmd(1'b1, 1'b1, 1'b1, 7'd5, 32'h0, 1'b0);
        chk("prereset_err", {31'b0, err}, 32'd1);
        start_read(7'd7, 32'h0, 1'b0);
        tick();
        chk("prereset_rd_valid", {31'b0, rd_valid}, 32'd1);
        rst = 1'b0;
        exp_q.delete();
        tick();
        chk("midresp_reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midresp_reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("midresp_reset_rd_data", rd_data, 32'd0);
        chk("midresp_reset_err", {31'b0, err}, 32'd0);
        chk("midresp_reset_cnt", {16'b0, access_cnt}, 32'd0);
        rst = 1'b1;
        tick();
        start_read(7'd7, c_RC ? 32'h0 : 32'h00001234, 1'b1);
        finish_read();
        chk("postreset_cnt", {16'b0, access_cnt}, 32'd1);

        // Saturation on the narrow-counter instance (DEPTH=128 so Addr 127 is legal).
        for (int i = 0; i < 255; i++) begin
            s_EN = 1'b1; s_W_EN = 1'b1; s_Addr = 7'(i); s_Data = 32'(i);
            tick();
        end
        s_EN = 1'b0; s_W_EN = 1'b0;
        chk("sat_at_max", {24'b0, s_access_cnt}, 32'd255);
        s_EN = 1'b1; s_W_EN = 1'b1; s_Addr = 7'd127; s_Data = 32'h1;
        tick();
        s_EN = 1'b0; s_W_EN = 1'b0;
        chk("sat_hold", {24'b0, s_access_cnt}, 32'd255);
        chk("sat_addr127_no_err", {31'b0, s_err}, 32'd0);

        tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
